// File: rtl/mul16_pkg.sv
// Shared types and constants for the shared 16-bit multiplier scheduler.
package mul16_pkg;

    localparam int MUL_W               = 16;
    localparam int PROD_W              = 32;
    localparam int DEFAULT_MUL_LATENCY = 18;

    // Scheduler sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul16_rr_scheduler_rr_pick.sv
// Combinational round-robin selector: the first requester after ptr (with wrap)
// wins. It is generic, so other shared-datapath schedulers can reuse it.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    // Scan N positions starting at ptr+1; the first active request found wins.
    always_comb begin
        int idx;
        idx    = 0;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mul16_rr_scheduler.sv
// Shares one fixed-latency, start-pulsed multiplier among N_REQ requesters.
// Requesters get round-robin grants. Only one operation is outstanding at a time.
module mul16_rr_scheduler
    import mul16_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    localparam int IDW         = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][MUL_W-1:0]    req_a,
    input  logic [N_REQ-1:0][MUL_W-1:0]    req_b,
    output logic [N_REQ-1:0]               rsp_valid,
    input  logic [N_REQ-1:0]               rsp_ready,
    output logic [PROD_W-1:0]              rsp_product,
    output logic [MUL_W-1:0]               mul_a,
    output logic [MUL_W-1:0]               mul_b,
    output logic                           mul_start,
    input  logic [PROD_W-1:0]              mul_product,
    output logic                           busy,
    output logic [IDW-1:0]                 owner_id
);

    localparam int CNTW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [MUL_W-1:0]    mul_a_q, mul_a_d;
    logic [MUL_W-1:0]    mul_b_q, mul_b_d;
    logic [PROD_W-1:0]   rsp_product_q, rsp_product_d;
    logic [IDW-1:0]      owner_id_q, owner_id_d;

    logic [N_REQ-1:0]    pick_gnt;
    logic [IDW-1:0]      pick_id;
    logic                pick_any;

    rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Next-state logic: grant in IDLE, pulse start, count the known latency, then hold the result.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_product_d = rsp_product_q;
        owner_id_d    = owner_id_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    mul_a_d    = req_a[pick_id];
                    mul_b_d    = req_b[pick_id];
                    owner_id_d = pick_id;
                    rr_ptr_d   = pick_id;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNTW'(MUL_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_product_d = mul_product;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                if (rsp_ready[owner_id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDW'(N_REQ - 1);
            cnt_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_product_q <= '0;
            owner_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            rsp_product_q <= rsp_product_d;
            owner_id_q    <= owner_id_d;
        end
    end

    // Output decode: the accept and response vectors are one-hot and decoded from state.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE && !reset) req_ready = pick_gnt;
        if (state_q == RESP)           rsp_valid[owner_id_q] = 1'b1;
    end

    assign mul_start   = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_product = rsp_product_q;
    assign owner_id    = owner_id_q;

endmodule

// File: tb/tb_mul16_rr_scheduler.sv
// Scoreboard bench for mul16_rr_scheduler, with a behavioural fixed-latency multiplier.
module tb_mul16_rr_scheduler;
    import mul16_pkg::*;

    localparam int N       = 4;
    localparam int LAT     = 18;
    localparam int RSP_LAT = LAT + 2;
    localparam int MIN_GAP = LAT + 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][15:0]    req_a;
    logic [N-1:0][15:0]    req_b;
    logic [N-1:0]          rsp_valid;
    logic [N-1:0]          rsp_ready;
    logic [31:0]           rsp_product;
    logic [15:0]           mul_a, mul_b;
    logic                  mul_start;
    logic [31:0]           mul_product;
    logic                  busy;
    logic [1:0]            owner_id;

    mul16_rr_scheduler #(.N_REQ(N), .MUL_LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_product (mul_product),
        .busy        (busy),
        .owner_id    (owner_id)
    );

    always #5 clk = ~clk;

    // Multiplier model: the product is readable from cycle T+LAT, and it is garbage before then.
    logic [15:0] ma, mb;
    int          mcnt;
    always @(posedge clk) begin
        if (reset) mcnt <= 0;
        else if (mul_start) begin
            ma <= mul_a; mb <= mul_b; mcnt <= 1;
        end else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
    end
    assign mul_product = (mcnt >= LAT) ? ({16'h0, ma} * {16'h0, mb}) : 32'hDEAD_BEEF;

    typedef struct { int id; logic [15:0] a; logic [15:0] b; } op_t;
    typedef struct { int id; logic [31:0] p; } exp_t;
    op_t  ops[$];
    exp_t exp_q[$];

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           acc_cyc  = -100;
    logic [N-1:0] force_vld = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester driver: present the oldest pending op per requester, and retire it on handshake.
    initial begin
        logic [N-1:0] hs;
        logic [N-1:0] found;
        req_valid = '0; req_a = '0; req_b = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (hs != '0) acc_cyc = cyc;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    int del;
                    del = -1;
                    for (int j = 0; j < ops.size(); j++)
                        if (del < 0 && ops[j].id == i) del = j;
                    if (del >= 0) ops.delete(del);
                end
            end
            found = '0;
            for (int i = 0; i < N; i++) begin
                req_a[i] = '0; req_b[i] = '0;
                for (int j = 0; j < ops.size(); j++) begin
                    if (!found[i] && ops[j].id == i) begin
                        found[i] = 1'b1; req_a[i] = ops[j].a; req_b[i] = ops[j].b;
                    end
                end
            end
            req_valid = found | force_vld;
        end
    end

    // Monitor: check response ordering, products, latency and start-pulse spacing.
    initial begin
        int           last_start;
        logic [N-1:0] prev_rsp;
        last_start = -1000;
        prev_rsp   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_start = -1000;
                prev_rsp   = '0;
            end else begin
                if (mul_start) begin
                    if (last_start >= 0) check("start_gap_ok", 64'(cyc - last_start >= MIN_GAP), 1);
                    check("start_after_accept", 64'(cyc - acc_cyc), 1);
                    last_start = cyc;
                end
                if (rsp_valid != '0 && prev_rsp == '0)
                    check("rsp_latency", 64'(cyc - acc_cyc), RSP_LAT);
                if (rsp_valid != '0) check("rsp_onehot", 64'($onehot(rsp_valid)), 1);
                if ((rsp_valid & rsp_ready) != '0) begin
                    int id;
                    id = 0;
                    for (int i = 0; i < N; i++) if (rsp_valid[i]) id = i;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp_id", 64'(id), 64'hFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rsp_id", 64'(id), 64'(e.id));
                        check("rsp_product", 64'(rsp_product), 64'(e.p));
                    end
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    task automatic push_op(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] p, input bit expect_rsp);
        ops.push_back('{id, a, b});
        if (expect_rsp) exp_q.push_back('{id, p});
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ops.size() != 0 || busy) && n < maxc) begin
            @(negedge clk); n++;
        end
        check("drain_in_time", 64'(n < maxc), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rsp_valid"},   64'(rsp_valid), 0);
        check({tag, "_busy"},        64'(busy), 0);
        check({tag, "_mul_start"},   64'(mul_start), 0);
        check({tag, "_mul_a"},       64'(mul_a), 0);
        check({tag, "_mul_b"},       64'(mul_b), 0);
        check({tag, "_owner_id"},    64'(owner_id), 0);
        check({tag, "_rsp_product"}, 64'(rsp_product), 0);
    endtask

    initial begin
        int n;
        rsp_ready = '1;
        reset     = 1'b1;
        // Single request queued during reset: no accept while reset is held high.
        push_op(0, 16'd3, 16'd5, 32'd15, 1);
        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 0);
        check_reset_vals("reset");
        @(posedge clk); #1 reset = 1'b0;
        wait_drain(60);

        // Full-scale operands and a zero operand on requester 2.
        push_op(2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1);
        wait_drain(60);
        push_op(2, 16'h1234, 16'h0000, 32'h0, 1);
        wait_drain(60);

        // Contention right after reset: the grant order is 0,1,2,3,0.
        @(posedge clk); #1 reset = 1'b1;
        push_op(0, 16'd2,      16'd3,     32'd6,        1);
        push_op(1, 16'd100,    16'd200,   32'd20000,    0);
        push_op(2, 16'hABCD,   16'h0010,  32'h000ABCD0, 0);
        push_op(3, 16'h8000,   16'h0002,  32'h00010000, 0);
        push_op(0, 16'hFFFF,   16'h0001,  32'h0000FFFF, 0);
        exp_q.push_back('{1, 32'd20000});
        exp_q.push_back('{2, 32'h000ABCD0});
        exp_q.push_back('{3, 32'h00010000});
        exp_q.push_back('{0, 32'h0000FFFF});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_drain(200);

        // Backpressure on requester 1, with requester 0 waiting behind it.
        @(posedge clk); #1 rsp_ready = 4'b1101;
        push_op(1, 16'd9, 16'd9, 32'd81, 1);
        push_op(0, 16'd4, 16'd4, 32'd16, 1);
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        check("bp_rsp_seen", 64'(n < 60), 1);
        repeat (10) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'h2);
            check("bp_product",   64'(rsp_product), 81);
            check("bp_req_ready", 64'(req_ready), 0);
            check("bp_no_start",  64'(mul_start), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy",  64'(busy), 0);
        check("bp_idle_grant", 64'(req_ready), 64'h1);
        wait_drain(60);

        // Reset during WAIT: the in-flight result is discarded, and requester 0 wins first again.
        push_op(2, 16'd5, 16'd5, 32'd25, 0);
        n = 0;
        while (mul_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("rst_start_seen", 64'(n < 10), 1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        push_op(3, 16'd7, 16'd6, 32'd42, 0);
        push_op(0, 16'd1, 16'd1, 32'd1,  1);
        exp_q.push_back('{3, 32'd42});
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        wait_drain(100);

        // Withdrawal: requester 1 pulses valid while busy, and is never served.
        push_op(0, 16'd11, 16'd13, 32'd143, 1);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("wd_busy_seen", 64'(n < 10), 1);
        @(posedge clk); #3 force_vld = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            check("wd_no_ready", 64'(req_ready), 0);
        end
        @(posedge clk); #3 force_vld = '0;
        wait_drain(60);
        repeat (30) @(negedge clk);
        check("wd_idle_busy", 64'(busy), 0);
        check("wd_no_rsp",    64'(rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul16_rr_scheduler.md
Name: mul16_rr_scheduler

Overview:
- Shares one sequential 16-bit shift-add multiplier (start-pulsed, fixed latency, no done flag) among N_REQ requesters.
- Per-requester valid/ready request and response channels.
- Round-robin grant.
- Sequences the multiplier: issues a one-cycle start, counts the known latency, captures the product, and returns it to the owning requester.
- Single outstanding operation.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- MUL_LATENCY, 18: cycles from the mul_start cycle T until mul_product is valid (readable in cycle T+MUL_LATENCY). The multiplier accepts a new start no earlier than cycle T+MUL_LATENCY.
- IDW, derived localparam: clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; also drives the multiplier's reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  one-hot accept, combinational.
- req_a  in  16*N_REQ  operand A; slice i belongs to requester i.
- req_b  in  16*N_REQ  operand B; slice i belongs to requester i.
- rsp_valid  out  N_REQ  one-hot result valid, for the owner only.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_product  out  32  shared result bus; meaningful only while any rsp_valid is high.
- mul_a  out  16  multiplier operand A, registered.
- mul_b  out  16  multiplier operand B, registered.
- mul_start  out  1  one-cycle start pulse.
- mul_product  in  32  multiplier result.
- busy  out  1  high in any state other than IDLE.
- owner_id  out  IDW  index of the current or last granted requester.

Behaviour:
- Reset (synchronous) sets:
  - state=IDLE, rr_ptr=N_REQ-1 (so requester 0 wins first), cnt=0.
  - mul_a=0, mul_b=0, mul_start=0, rsp_product=0, owner_id=0.
  - rsp_valid=0, busy=0, and req_ready forced 0 while reset is high.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Round-robin pick among req_valid, searching from rr_ptr+1 with wrap.
  - req_ready[g]=1 for the winner g only, combinationally.
  - On handshake: latch req_a[g]/req_b[g] into mul_a/mul_b, set owner_id=g and rr_ptr=g, then go to ISSUE.
  - With no valid requests, stay in IDLE and rr_ptr is unchanged.
- ISSUE (cycle T):
  - mul_start=1 for exactly this cycle.
  - Load cnt=MUL_LATENCY-1 and go to WAIT.
- WAIT:
  - If cnt==0 (this is cycle T+MUL_LATENCY): rsp_product<=mul_product, go to RESP.
  - Otherwise cnt<=cnt-1.
- RESP:
  - rsp_valid[owner_id]=1 and rsp_product is held stable.
  - On rsp_ready[owner_id]: go to IDLE.
  - rsp_ready on other indices is ignored.
- Latency: request accepted in cycle A gives rsp_valid first high in cycle A+MUL_LATENCY+2 (20 by default).
- Minimum spacing: a new ISSUE occurs at T+MUL_LATENCY+3 at the earliest. This is at least T+MUL_LATENCY, so the multiplier is never restarted while running.
- mul_start is 0 in every state except ISSUE. mul_a/mul_b stay stable from the IDLE handshake until the next handshake.
- Requesters hold req_valid and operands stable until ready. Withdrawal before grant is legal and simply drops the requester from arbitration.
- req_ready is all 0 outside IDLE. Requests arriving during an operation wait; none are lost.
- Reset mid-operation (any state): return to reset values immediately. The in-flight result is discarded and no rsp_valid is produced for it.
- Product width is 32 with no truncation; operands are unsigned.

Decomposition:
- Shared package mul16_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - MUL_W=16 and PROD_W=32;
  - the DEFAULT_MUL_LATENCY=18 constant.
- One sub-module, rr_pick: combinational round-robin selector taking the request vector and pointer, giving a one-hot grant and an index. It is reusable by other shared-datapath schedulers.

Test Plan:
- Single request: req0 with a=3, b=5, accepted at cycle A -> rsp_valid[0] high at A+20, rsp_product=15, mul_start exactly one cycle at A+1.
- Full scale: req2 with a=0xFFFF, b=0xFFFF -> rsp_product=0xFFFE0001; a=0x1234, b=0 -> 0.
- Contention: all four requesters continuously valid after reset -> grant order 0,1,2,3,0. Each gets its own product, and no two mul_start pulses are closer than 21 cycles.
- Backpressure: rsp_ready[1] held low for 10 cycles in RESP -> rsp_valid[1] and rsp_product stay stable, req_ready stays all 0, and no mul_start occurs. Releasing rsp_ready returns the FSM to IDLE the next cycle.
- Reset mid-WAIT: assert reset 5 cycles after mul_start -> all outputs at reset values the next cycle, with no response. After release, req3 with a=7, b=6 -> rsp_product=42, correct latency, requester 0 priority restored.
- Withdrawal: req1 raises and drops valid while busy -> no grant to 1 and no response to 1; req0 completes normally.
